pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc.sv | 32 +++
 tb/tb_pc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc.sv
// Program counter register for the pipeline front end.
// Holds the current fetch address and loads the next address (chosen
// upstream: sequential or branch target) when the front end is not stalled.
// The reset input keeps its historical name arst_n but is a synchronous,
// active-high reset.
module pc #(
  parameter int unsigned             PC_SIZE      = 32,
  parameter logic [PC_SIZE-1:0]      RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               arst_n,  // synchronous, active-high
  input  logic               en_in,
  input  logic [PC_SIZE-1:0] pc_in,
  output logic [PC_SIZE-1:0] pc_out
);

  logic [PC_SIZE-1:0] r_pc;

  // Reset beats enable; a stall holds the register and ignores pc_in entirely.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (arst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (en_in) begin
      r_pc <= pc_in;
    end
  end

  // Output comes straight from the register; no path from pc_in to pc_out.
  assign pc_out = r_pc;

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: the stimulus process pushes the expected pc_out
// after each edge, and a monitor process pops and compares on the falling edge.
module tb_pc;

  localparam int unsigned PC_SIZE = 32;

  typedef struct {
    logic [PC_SIZE-1:0] exp;
    string              name;
  } exp_t;

  logic               clk;
  logic               arst_n;
  logic               en_in;
  logic [PC_SIZE-1:0] pc_in;
  logic [PC_SIZE-1:0] pc_out;

  exp_t q_exp[$];
  int   checks;
  int   failures;

  pc #(
    .PC_SIZE      (PC_SIZE),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .en_in  (en_in),
    .pc_in  (pc_in),
    .pc_out (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PC_SIZE-1:0] act,
                       input logic [PC_SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: pc_out=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then queue the value pc_out must show after the edge.
  task automatic drive(input logic rst, input logic en,
                       input logic [PC_SIZE-1:0] pc_next,
                       input logic [PC_SIZE-1:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    arst_n = rst;
    en_in  = en;
    pc_in  = pc_next;
    @(posedge clk);
    #1;
    e.exp  = exp;
    e.name = name;
    q_exp.push_back(e);
  endtask

  // Monitor: compare the oldest outstanding expectation away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        check(e.name, pc_out, e.exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    arst_n   = 1'b1;
    en_in    = 1'b1;
    pc_in    = 32'h1234_5678;

    // Reset held two cycles with enable and a live pc_in
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, "reset_edge1");
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, "reset_edge2");

    // Sequential loads
    drive(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, "seq_4");
    drive(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0008, "seq_8");

    // Three-cycle stall with changing / unknown pc_in, then resume
    drive(1'b0, 1'b0, 32'h0000_000C, 32'h0000_0008, "stall_1");
    drive(1'b0, 1'b0, 'x,            32'h0000_0008, "stall_2_x");
    drive(1'b0, 1'b0, 32'h0000_000C, 32'h0000_0008, "stall_3");
    drive(1'b0, 1'b1, 32'h0000_000C, 32'h0000_000C, "resume_C");

    // Branch targets
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, "branch_8000_0000");
    drive(1'b0, 1'b1, 32'h8000_0004, 32'h8000_0004, "branch_8000_0004");

    // Wrap-around and misaligned values stored unmodified
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "bound_FFFF_FFFC");
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, "bound_wrap_0");
    drive(1'b0, 1'b1, 32'h0000_0006, 32'h0000_0006, "misaligned_6");
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");

    // Reset priority over enable
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, "load_100");
    drive(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0000, "reset_priority");

    // Reset during a stall, then synchronous release
    drive(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, "load_40");
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, "reset_in_stall");
    drive(1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, "release_stalled");
    drive(1'b0, 1'b1, 32'h0000_0044, 32'h0000_0044, "first_load_44");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: outstanding=%0d expected=0", q_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
